hazard_stall_unit: RTL and testbench



---
 rtl/hazard_stall_unit_if.sv | 37 +++
 rtl/hazard_stall_unit.sv | 124 ++++++++++++
 tb/tb_hazard_stall_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side bundle for the hazard/stall unit: ID/EX hazard inputs,
// mult/div tracking inputs, and the stall/flush controls it returns.
interface hazard_stall_unit_if #(
  parameter int CNT_W = 16
);
  logic             ID_EX_MemRead;
  logic [4:0]       ID_EX_RegRt;
  logic [4:0]       IF_ID_RegRs;
  logic [4:0]       IF_ID_RegRt;
  logic             IF_ID_UsesRt;
  logic             IF_ID_ReadsHiLo;
  logic             IF_ID_IsMD;
  logic             md_start;
  logic             md_is_div;
  logic             branch_taken;
  logic             PCWrite;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic             md_busy;
  logic             md_done;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output ID_EX_MemRead, ID_EX_RegRt, IF_ID_RegRs, IF_ID_RegRt, IF_ID_UsesRt,
    output IF_ID_ReadsHiLo, IF_ID_IsMD, md_start, md_is_div, branch_taken,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, md_busy, md_done,
    input  stall_cycles
  );

  modport slave (
    input  ID_EX_MemRead, ID_EX_RegRt, IF_ID_RegRs, IF_ID_RegRt, IF_ID_UsesRt,
    input  IF_ID_ReadsHiLo, IF_ID_IsMD, md_start, md_is_div, branch_taken,
    output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, md_busy, md_done,
    output stall_cycles
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush generator for the 5-stage MIPS pipeline: load-use bubbles,
// HI/LO interlock against the multi-cycle mult/div unit, and branch flushes.
module hazard_stall_unit #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  hazard_stall_unit_if.slave hz
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int MD_W    = $clog2(MAX_LAT) + 1;
  localparam logic [MD_W-1:0]  MUL_LOAD = MD_W'(MUL_LAT - 1);
  localparam logic [MD_W-1:0]  DIV_LOAD = MD_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LOADUSE = 2'd1,
    MDBUSY  = 2'd2
  } state_t;

  state_t           r_state;
  logic [MD_W-1:0]  r_md_cnt;
  logic [CNT_W-1:0] r_stall_cycles;

  logic w_lu_hit;
  logic w_md_hold;
  logic w_stall;
  logic w_pc_write;
  logic w_if_id_write;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_md_busy;
  logic w_md_done;

  // Hazard detection; LOADUSE masks lu_hit so each load-use costs one bubble.
  always_comb begin
    w_lu_hit  = hz.ID_EX_MemRead && (hz.ID_EX_RegRt != 5'd0) &&
                ((hz.ID_EX_RegRt == hz.IF_ID_RegRs) ||
                 (hz.IF_ID_UsesRt && (hz.ID_EX_RegRt == hz.IF_ID_RegRt)));
    w_md_hold = (r_state == MDBUSY) && (r_md_cnt != {MD_W{1'b0}}) &&
                (hz.IF_ID_ReadsHiLo || hz.IF_ID_IsMD);
    w_stall   = (w_lu_hit && (r_state != LOADUSE)) || w_md_hold;
  end

  // Same-cycle pipeline controls: reset forces idle, then branch beats stall.
  always_comb begin
    w_pc_write    = 1'b1;
    w_if_id_write = 1'b1;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    w_md_busy     = 1'b0;
    w_md_done     = 1'b0;
    if (reset) begin
      w_pc_write    = 1'b1;
    end else begin
      w_md_busy = (r_state == MDBUSY);
      w_md_done = (r_state == MDBUSY) && (r_md_cnt == {MD_W{1'b0}});
      if (hz.branch_taken) begin
        w_if_id_flush = 1'b1;
        w_id_ex_flush = 1'b1;
      end else if (w_stall) begin
        w_pc_write    = 1'b0;
        w_if_id_write = 1'b0;
        w_id_ex_flush = 1'b1;
      end else begin
        w_id_ex_flush = 1'b0;
      end
    end
  end

  // State machine, mult/div countdown and saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= RUN;
      r_md_cnt       <= {MD_W{1'b0}};
      r_stall_cycles <= {CNT_W{1'b0}};
    end else begin
      if (!w_pc_write && (r_stall_cycles != CNT_MAX)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end else begin
        r_stall_cycles <= r_stall_cycles;
      end
      case (r_state)
        RUN: begin
          if (hz.md_start) begin
            r_state  <= MDBUSY;
            r_md_cnt <= hz.md_is_div ? DIV_LOAD : MUL_LOAD;
          end else if (w_lu_hit && !hz.branch_taken) begin
            r_state  <= LOADUSE;
          end else begin
            r_state  <= RUN;
          end
        end
        LOADUSE: begin
          r_state <= RUN;
        end
        MDBUSY: begin
          if (r_md_cnt != {MD_W{1'b0}}) begin
            r_md_cnt <= r_md_cnt - MD_W'(1);
          end else begin
            r_state  <= RUN;
          end
        end
        default: begin
          r_state  <= RUN;
          r_md_cnt <= {MD_W{1'b0}};
        end
      endcase
    end
  end

  assign hz.PCWrite      = w_pc_write;
  assign hz.IF_ID_Write  = w_if_id_write;
  assign hz.IF_ID_Flush  = w_if_id_flush;
  assign hz.ID_EX_Flush  = w_id_ex_flush;
  assign hz.md_busy      = w_md_busy;
  assign hz.md_done      = w_md_done;
  assign hz.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench: the stimulus process pushes model predictions, a monitor
// process pops and compares them against the DUT each cycle.
module tb_hazard_stall_unit;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;
  localparam int CNT_W   = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       reset;
    logic       memread;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       hilo;
    logic       is_md;
    logic       md_start;
    logic       is_div;
    logic       br;
  } stim_t;

  typedef struct packed {
    logic             pcw;
    logic             ifidw;
    logic             ifidf;
    logic             idexf;
    logic             busy;
    logic             done;
    logic             cnt_known;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk;
  logic reset;
  hazard_stall_unit_if #(.CNT_W(CNT_W)) hz ();

  hazard_stall_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model: busy cycles still owed by mult/div, a one-shot mask
  // after a load-use bubble, and the stall count.
  int m_busy_left = 0;
  bit m_mask      = 1'b0;
  int m_cnt       = 0;
  bit m_cnt_known = 1'b0;

  task automatic apply(input stim_t s);
    exp_t e;
    bit   lu;
    bit   hold;
    bit   stall;
    @(posedge clk);
    #1;
    reset              = s.reset;
    hz.ID_EX_MemRead   = s.memread;
    hz.ID_EX_RegRt     = s.ex_rt;
    hz.IF_ID_RegRs     = s.rs;
    hz.IF_ID_RegRt     = s.rt;
    hz.IF_ID_UsesRt    = s.uses_rt;
    hz.IF_ID_ReadsHiLo = s.hilo;
    hz.IF_ID_IsMD      = s.is_md;
    hz.md_start        = s.md_start;
    hz.md_is_div       = s.is_div;
    hz.branch_taken    = s.br;

    lu    = s.memread && (s.ex_rt != 5'd0) &&
            ((s.ex_rt == s.rs) || (s.uses_rt && (s.ex_rt == s.rt)));
    hold  = (m_busy_left > 1) && (s.hilo || s.is_md);
    stall = (lu && !m_mask) || hold;

    e           = '0;
    e.cnt_known = m_cnt_known;
    e.cnt       = CNT_W'(m_cnt);
    e.pcw       = 1'b1;
    e.ifidw     = 1'b1;
    if (!s.reset) begin
      e.busy = (m_busy_left > 0);
      e.done = (m_busy_left == 1);
      if (s.br) begin
        e.ifidf = 1'b1;
        e.idexf = 1'b1;
      end else if (stall) begin
        e.pcw   = 1'b0;
        e.ifidw = 1'b0;
        e.idexf = 1'b1;
      end
    end
    exp_q.push_back(e);

    if (s.reset) begin
      m_busy_left = 0;
      m_mask      = 1'b0;
      m_cnt       = 0;
      m_cnt_known = 1'b1;
    end else begin
      if (!e.pcw && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (m_busy_left > 0) begin
        m_busy_left = m_busy_left - 1;
      end else if (m_mask) begin
        m_mask = 1'b0;
      end else if (s.md_start) begin
        m_busy_left = s.is_div ? DIV_LAT : MUL_LAT;
      end else if (lu && !s.br) begin
        m_mask = 1'b1;
      end
    end
  endtask

  task automatic hold_n(input stim_t s, input int n);
    for (int k = 0; k < n; k++) apply(s);
  endtask

  // Monitor: compare every presented cycle against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (hz.PCWrite !== e.pcw || hz.IF_ID_Write !== e.ifidw ||
            hz.IF_ID_Flush !== e.ifidf || hz.ID_EX_Flush !== e.idexf ||
            hz.md_busy !== e.busy || hz.md_done !== e.done ||
            (e.cnt_known && hz.stall_cycles !== e.cnt)) begin
          n_fail++;
          $display("FAIL ctrl cyc=%0d got pcw=%b ifidw=%b ifidf=%b idexf=%b busy=%b done=%b cnt=%0d exp pcw=%b ifidw=%b ifidf=%b idexf=%b busy=%b done=%b cnt=%0d",
                   cyc, hz.PCWrite, hz.IF_ID_Write, hz.IF_ID_Flush, hz.ID_EX_Flush,
                   hz.md_busy, hz.md_done, hz.stall_cycles,
                   e.pcw, e.ifidw, e.ifidf, e.idexf, e.busy, e.done, e.cnt);
        end
      end
    end
  end

  initial begin
    stim_t idle;
    stim_t s;
    int    budget;
    idle  = '0;
    reset = 1'b1;
    apply(idle);
    idle.reset = 1'b1;
    hold_n(idle, 2);
    idle.reset = 1'b0;
    hold_n(idle, 2);

    // lw $8 then add using rs=8: one bubble, then released in LOADUSE
    s = idle; s.memread = 1'b1; s.ex_rt = 5'd8; s.rs = 5'd8;
    hold_n(s, 2);
    apply(idle);
    // load to $0 with rs=0, and rt match without UsesRt
    s = idle; s.memread = 1'b1;
    apply(s);
    s.ex_rt = 5'd9; s.rt = 5'd9;
    apply(s);
    s.uses_rt = 1'b1;
    hold_n(s, 2);

    // divide with mfhi waiting in ID, from a fresh counter
    s = idle; s.reset = 1'b1;
    apply(s);
    hold_n(idle, 4);
    s = idle; s.md_start = 1'b1; s.is_div = 1'b1; s.hilo = 1'b1;
    apply(s);
    s = idle; s.hilo = 1'b1; s.md_start = 1'b1;
    hold_n(s, DIV_LAT + 2);
    apply(idle);

    // back-to-back mults
    s = idle; s.md_start = 1'b1; s.is_md = 1'b1;
    apply(s);
    s.md_start = 1'b0;
    hold_n(s, MUL_LAT);
    s.md_start = 1'b1;
    apply(s);
    s.md_start = 1'b0;
    hold_n(s, MUL_LAT + 1);

    // branch together with a load-use hit
    s = idle; s.memread = 1'b1; s.ex_rt = 5'd4; s.rs = 5'd4; s.br = 1'b1;
    apply(s);
    s.br = 1'b0;
    hold_n(s, 2);

    // reset in the middle of a divide
    s = idle; s.md_start = 1'b1; s.is_div = 1'b1;
    apply(s);
    s = idle; s.hilo = 1'b1;
    hold_n(s, 10);
    s.reset = 1'b1;
    apply(s);
    s.reset = 1'b0;
    hold_n(s, 3);

    // randomized traffic
    for (int i = 0; i < 900; i++) begin
      s          = idle;
      s.reset    = ($urandom_range(99) < 2);
      s.memread  = $urandom_range(1);
      s.ex_rt    = 5'($urandom_range(3));
      s.rs       = 5'($urandom_range(3));
      s.rt       = 5'($urandom_range(3));
      s.uses_rt  = $urandom_range(1);
      s.hilo     = ($urandom_range(3) == 0);
      s.is_md    = ($urandom_range(3) == 0);
      s.md_start = ($urandom_range(9) == 0);
      s.is_div   = ($urandom_range(3) == 0);
      s.br       = ($urandom_range(6) == 0);
      apply(s);
    end

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    #1;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
